// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels
// and the double-width result bus.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_if;
    import div_pkg::*;

    logic                    signed_div_i;
    logic [31:0]             opdata1_i;
    logic [31:0]             opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// 32-bit restoring divider, one quotient bit per cycle, result = {rem, quo}.
// Signed support is built only when DIV_SIGNED_EN is defined; otherwise unsigned.
module div
    import div_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    div_state_e              state_q;
    logic [5:0]              cnt_q;
    logic [31:0]             rem_q;
    logic [31:0]             quo_q;
    logic [31:0]             divisor_q;
    logic [DoubleRegBus-1:0] result_q;
    logic                    ready_q;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [32:0] partial;
    logic [32:0] diff;
    logic        borrow;

    // partial < 2*divisor always, so bit 32 of the 33-bit difference is the borrow.
    assign partial = {rem_q, quo_q[31]};
    assign diff    = partial - {1'b0, divisor_q};
    assign borrow  = diff[32];

`ifdef DIV_SIGNED_EN
    logic op1_neg;
    logic op2_neg;
    logic neg_quo_q;
    logic neg_rem_q;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[31];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[31];
    assign op1_mag = op1_neg ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign op2_mag = op2_neg ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    assign quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
`else
    logic unused_signed_div;

    assign unused_signed_div = bus.signed_div_i;
    assign op1_mag = bus.opdata1_i;
    assign op2_mag = bus.opdata2_i;
    assign quo_fix = quo_q;
    assign rem_fix = rem_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                DivFree: begin
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q   <= DivOn;
                            cnt_q     <= 6'd0;
                            rem_q     <= 32'd0;
                            quo_q     <= op1_mag;
                            divisor_q <= op2_mag;
`ifdef DIV_SIGNED_EN
                            neg_quo_q <= op1_neg ^ op2_neg;
                            neg_rem_q <= op1_neg;
`endif
                        end
                    end
                end
                DivByZero: begin
                    result_q <= '0;
                    state_q  <= DivEnd;
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        state_q  <= DivFree;
                        cnt_q    <= 6'd0;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end else if (cnt_q == 6'd32) begin
                        result_q <= {rem_fix, quo_fix};
                        cnt_q    <= 6'd0;
                        state_q  <= DivEnd;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                        if (borrow) begin
                            rem_q <= partial[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end else begin
                            rem_q <= diff[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end
                    end
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        state_q  <= DivFree;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                    end else begin
                        ready_q <= DivResultReady;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Bench for div: directed vector table, handshake corner sequences and random
// operations checked against an arithmetic reference model.
module tb_div;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    div_if dif ();

    div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sgn;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        logic   unused_s;
        unused_s = s;
        if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
`endif
        sa = longint'(a);
        sb = longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Caller has start_i high before the next rising edge, which is E0.
    task automatic wait_done(input logic [63:0] exp, input int exp_lat, input string name,
                             input bit annul_after_e0, input bit annul_in_end);
        int n;
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = ~dif.signed_div_i;
        if (annul_after_e0) dif.annul_i = 1'b1;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (dif.ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: ready_o not seen after %0d edges, expected %0d", name, n, exp_lat);
        end else begin
            check({name, "_latency"}, 64'(n), 64'(exp_lat));
            check({name, "_result"}, dif.result_o, exp);
            if (annul_in_end) dif.annul_i = 1'b1;
            @(posedge clk);
            #1;
            check({name, "_hold"}, {dif.ready_o, dif.result_o[62:0]}, {1'b1, exp[62:0]});
        end
        @(negedge clk);
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop"}, {63'd0, dif.ready_o} | dif.result_o, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_lat, input string name);
        @(negedge clk);
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.signed_div_i = s;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b0;
        wait_done(exp, exp_lat, name, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        bit          seen;

        vecs[0] = '{32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, 34};
`ifdef DIV_SIGNED_EN
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, 34};
        vecs[8] = '{32'd7,         32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD, 34};
`else
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 64'h00000001_7FFFFFFC, 34};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h80000000_00000000, 34};
        vecs[8] = '{32'd7,         32'hFFFFFFFE,  1'b1, 64'h00000007_00000000, 34};
`endif
        vecs[2] = '{32'h12345678,  32'd0,         1'b0, 64'h0,                 2};
        vecs[3] = '{32'hFFFFFFFF,  32'h10,        1'b0, 64'h0000000F_0FFFFFFF, 34};
        vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'h00000000_00000001, 34};
        vecs[6] = '{32'd5,         32'hFFFFFFFF,  1'b0, 64'h00000005_00000000, 34};
        vecs[7] = '{32'hFFFFFFFF,  32'h80000001,  1'b0, 64'h7FFFFFFE_00000001, 34};

        // Request held through reset is taken on the first edge with rst low.
        dif.opdata1_i    = 32'd1000;
        dif.opdata2_i    = 32'd3;
        dif.signed_div_i = 1'b0;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {63'd0, dif.ready_o} | dif.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(64'h00000001_0000014D, 34, "start_through_reset", 1'b0, 1'b0);

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].op1, vecs[i].op2, vecs[i].sgn, vecs[i].exp_res, vecs[i].exp_lat,
                   $sformatf("vec%0d", i));

        // Annul in the middle of an operation: no result, then a clean retry.
        @(negedge clk);
        dif.opdata1_i = 32'hDEADBEEF;
        dif.opdata2_i = 32'd3;
        dif.start_i   = 1'b1;
        seen = 0;
        @(posedge clk);
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= dif.ready_o;
        end
        @(negedge clk);
        dif.annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_result", dif.result_o, 64'd0);
        @(negedge clk);
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= dif.ready_o;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_op(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 34, "after_annul");

        // Annul is ignored in DivByZero and DivEnd.
        @(negedge clk);
        dif.opdata1_i = 32'h55; dif.opdata2_i = 32'd0; dif.start_i = 1'b1;
        wait_done(64'd0, 2, "annul_byzero", 1'b1, 1'b0);
        @(negedge clk);
        dif.opdata1_i = 32'd50; dif.opdata2_i = 32'd6; dif.start_i = 1'b1;
        wait_done(64'h00000002_00000008, 34, "annul_end", 1'b0, 1'b1);

        // start with annul high in DivFree is not accepted until annul drops.
        @(negedge clk);
        dif.opdata1_i = 32'd9; dif.opdata2_i = 32'd4; dif.start_i = 1'b1; dif.annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("free_annul_idle", {63'd0, dif.ready_o}, 64'd0);
        @(negedge clk);
        dif.annul_i = 1'b0;
        wait_done(64'h00000001_00000002, 34, "free_annul_release", 1'b0, 1'b0);

        // Reset mid-operation, request still held, completes after reset release.
        @(negedge clk);
        dif.opdata1_i = 32'h12345678; dif.opdata2_i = 32'd9; dif.signed_div_i = 1'b0;
        dif.start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_outputs", {63'd0, dif.ready_o} | dif.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(model(32'h12345678, 32'd9, 1'b0), 34, "after_reset", 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = $urandom_range(1, 15);
                1: b = 32'd0;
                2: b = 32'hFFFFFFF8 | 32'($urandom_range(0, 7));
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op(a, b, s, model(a, b, s), (b == 32'd0) ? 2 : 34, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 = signed division, 0 = unsigned.
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-006 SHALL have port start_i, input, 1 bit: request from EX; held high until ready_o is seen.
REQ-007 SHALL have port annul_i, input, 1 bit: abort the operation in progress.
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o is valid.

Function
REQ-010 SHALL implement an FSM with states DivFree, DivByZero, DivOn and DivEnd.
REQ-011 In DivFree with start_i=1 and annul_i=0 at edge E0: if opdata2_i==0, SHALL go to DivByZero; otherwise SHALL go to DivOn, latch the operands and set cnt=0.
REQ-012 In DivFree with start_i=0, or with annul_i=1, SHALL stay in DivFree.
REQ-013 DivByZero SHALL go to DivEnd on the next edge with result 0; ready_o SHALL be 1 after edge E0+2.
REQ-014 Each DivOn cycle SHALL do one restoring shift-subtract step using a 33-bit subtract of the divisor from the partial remainder, and SHALL increment cnt (6 bits).
REQ-015 When cnt==32, SHALL apply sign fixup, load result_o and go to DivEnd; ready_o SHALL be 1 after edge E0+34.
REQ-016 In DivEnd, ready_o SHALL be 1 and result_o held stable while start_i stays 1.
REQ-017 In DivEnd with start_i=0, SHALL go to DivFree; ready_o=0 and result_o=0 after that edge.
REQ-018 annul_i=1 in DivOn SHALL force DivFree on that edge, with ready_o=0 and result_o=0.
REQ-019 annul_i SHALL have no effect in DivEnd or DivByZero.
REQ-020 Signed mode: SHALL divide the magnitudes; quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
REQ-021 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0 (two's-complement wrap), with no exception output.
REQ-022 Operand changes after E0 SHALL NOT affect the operation in progress.
REQ-023 A new request SHALL be accepted on the first DivFree cycle after return, so back-to-back operations are separated by at least one DivFree cycle.

Reset
REQ-024 With rst=1 at an edge, SHALL set state=DivFree, cnt=0, ready_o=0 and result_o=0, including mid-operation.
REQ-025 start_i held through reset SHALL be accepted on the first edge with rst=0.

Configuration
REQ-026 When macro DIV_SIGNED_EN is defined, SHALL implement signed_div_i as in REQ-020/REQ-021.
REQ-027 When DIV_SIGNED_EN is undefined, SHALL ignore signed_div_i, treat all operands as unsigned and omit the negation logic; timing is unchanged.

Structure
REQ-028 The shared defines file SHALL hold DivFree, DivByZero, DivOn and DivEnd (2-bit), DivResultReady/DivResultNotReady, DivStart/DivStop and DoubleRegBus (64).
REQ-029 SHALL be a single module with no sub-module; the 33-bit step subtractor is inline.
REQ-030 Instantiation in the core top and the EX stall/handshake wiring are outside this block.

Verification
REQ-031 Unsigned 100/7 -> ready_o after E0+34 with result_o=0x00000002_0000000E.
REQ-032 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; with DIV_SIGNED_EN undefined -> 0x00000001_7FFFFFFC.
REQ-033 Any dividend / 0 -> ready_o after E0+2 with result_o=0; drop start_i -> ready_o=0 on the next edge.
REQ-034 annul_i pulsed at cnt==10 -> DivFree, ready_o never asserted; a following 0xFFFFFFFF/0x10 request gives 0x0000000F_0FFFFFFF.
REQ-035 rst asserted at cnt==20 -> all outputs 0 on the next edge; a request with start_i still high completes correctly 34 edges after rst drops.
REQ-036 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000.
